io_tx_module: RTL

Hardware-to-software transmitter for the PIO link between the FPGA game logic and the NIOS II software; it is the counterpart of `io_module`, which receives data from software. Game-side blocks (collision, score, level events) push 9-bit words through a valid/ready port into a small FIFO. The block presents each word to software on `to_sw_data`/`to_sw_sig` with the same alternating 1/2 phase-code, four-phase handshake that software uses toward hardware. Software acknowledges each word on `to_hw_sig`.

---
 rtl/io_pkg.sv | 14 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/io_tx_module.sv | 104 ++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared PIO link definitions: phase codes, transmitter FSM states and data width.
package io_pkg;
  localparam int IO_DATA_W = 9;

  localparam logic [1:0] SIG_IDLE = 2'd0;
  localparam logic [1:0] SIG_PH_A = 2'd1;
  localparam logic [1:0] SIG_PH_B = 2'd2;

  typedef enum logic [1:0] {IDLE, PRESENT, RELEASE} tx_state_t;

  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    return (ph == SIG_PH_A) ? SIG_PH_B : SIG_PH_A;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push is ignored when full, pop when empty.
module sync_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [DATA_W-1:0]        head
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              do_push, do_pop;

  assign full    = (fill_q == FILL_W'(DEPTH));
  assign empty   = (fill_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign fill    = fill_q;
  assign head    = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/io_tx_module.sv
// Hardware-to-software PIO transmitter: buffers game words and hands them to
// software with an alternating 1/2 phase-code four-phase handshake.
module io_tx_module
  import io_pkg::*;
#(
  parameter int DATA_W = IO_DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                   clk50,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      to_sw_data,
  output logic [1:0]             to_sw_sig,
  input  logic [1:0]             to_hw_sig,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   proto_err
);
  logic [1:0]        ack_meta_q, ack_s_q;
  tx_state_t         state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [1:0]        sig_q, sig_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk50),
    .rst     (reset),
    .push    (in_valid),
    .pop     (pop),
    .wr_data (in_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .fill    (fill),
    .head    (fifo_head)
  );

  assign in_ready   = !fifo_full;
  assign to_sw_data = data_q;
  assign to_sw_sig  = sig_q;
  assign proto_err  = err_q;

  // The head word stays in the FIFO until software releases, so a stalled
  // partner naturally backpressures the producer.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    sig_d   = sig_q;
    data_d  = data_q;
    err_d   = err_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          data_d  = fifo_head;
          sig_d   = phase_q;
          state_d = PRESENT;
        end else begin
          sig_d = SIG_IDLE;
        end
      end
      PRESENT: begin
        if (ack_s_q == phase_q) begin
          sig_d   = SIG_IDLE;
          state_d = RELEASE;
        end else if (ack_s_q != SIG_IDLE) begin
          err_d = 1'b1;
        end
      end
      RELEASE: begin
        if (ack_s_q == SIG_IDLE) begin
          pop     = 1'b1;
          phase_d = next_phase(phase_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      ack_meta_q <= SIG_IDLE;
      ack_s_q    <= SIG_IDLE;
      state_q    <= IDLE;
      phase_q    <= SIG_PH_A;
      sig_q      <= SIG_IDLE;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      ack_meta_q <= to_hw_sig;
      ack_s_q    <= ack_meta_q;
      state_q    <= state_d;
      phase_q    <= phase_d;
      sig_q      <= sig_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end
endmodule
